// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: sequencer for the 128-set direct-mapped dCache tag array.
// Arbitrates core lookups, miss refill writes and fence walks over one array.
// Ports: i_req_* / o_req_ready   lookup request and accept
//        o_rsp_*                 registered one-cycle lookup result
//        i_refill_done           refill finished for the outstanding miss
//        i_fence_req / o_fence_done   flush walk request and done strobe
//        o_wb_* / i_wb_done      dirty-line write-back handshake
//        o_ary_* / i_ary_dout    tag array port (read is combinational)
// Macro DCACHE_FENCE_INV_EN: fence invalidates every entry (fence.i style);
// when undefined the fence only clears dirty bits and keeps valid bits.
module dcache_tag_ctrl #(
  parameter int TAG_W = 53,
  parameter int ENT_W = TAG_W + 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [63:0]      i_req_addr,
  input  logic             i_req_wr,
  output logic             o_rsp_valid,
  output logic             o_rsp_hit,
  output logic             o_rsp_vdirty,
  output logic [TAG_W-1:0] o_rsp_vtag,
  input  logic             i_refill_done,
  input  logic             i_fence_req,
  output logic             o_fence_done,
  output logic             o_wb_valid,
  output logic [6:0]       o_wb_index,
  output logic [TAG_W-1:0] o_wb_tag,
  input  logic             i_wb_done,
  output logic             o_ary_wen,
  output logic [6:0]       o_ary_addr,
  output logic [ENT_W-1:0] o_ary_din,
  input  logic [ENT_W-1:0] i_ary_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_FL_RD,
    S_FL_WB,
    S_FL_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [6:0]       m_idx_q, m_idx_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d;
  logic             m_wr_q, m_wr_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic             rsp_vdirty_q, rsp_vdirty_d;
  logic [TAG_W-1:0] rsp_vtag_q, rsp_vtag_d;

  logic             wb_valid_q, wb_valid_d;
  logic [6:0]       wb_index_q, wb_index_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

  logic             req_ready;
  logic             ary_wen;
  logic [6:0]       ary_addr;
  logic [ENT_W-1:0] ary_din;
  logic             fence_done;

  // Array entry fields
  logic             e_val;
  logic             e_dirty;
  logic [TAG_W-1:0] e_tag;

  assign e_val   = i_ary_dout[ENT_W-1];
  assign e_dirty = i_ary_dout[ENT_W-2];
  assign e_tag   = i_ary_dout[TAG_W-1:0];

  // Request address fields
  logic [6:0]       req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr;

  assign req_idx     = i_req_addr[10:4];
  assign req_tag     = i_req_addr[63 -: TAG_W];
  assign unused_addr = ^i_req_addr[3:0];

  logic hit;
  logic accept;
  logic last;
  logic wb_need;

  assign hit     = e_val && (e_tag == req_tag);
  assign accept  = (state_q == S_IDLE) && i_req_valid && !i_fence_req;
  assign last    = (cnt_q == 7'd127);
  assign wb_need = e_val && e_dirty;

  // Fence clean action for the entry at the walk counter
  logic             cl_wen;
  logic [ENT_W-1:0] cl_din;

`ifdef DCACHE_FENCE_INV_EN
  assign cl_wen = 1'b1;
  assign cl_din = {2'b00, e_tag};
`else
  assign cl_wen = e_dirty;
  assign cl_din = {e_val, 1'b0, e_tag};
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      m_idx_q      <= '0;
      m_tag_q      <= '0;
      m_wr_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_vdirty_q <= 1'b0;
      rsp_vtag_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_index_q   <= '0;
      wb_tag_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_idx_q      <= m_idx_d;
      m_tag_q      <= m_tag_d;
      m_wr_q       <= m_wr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_vdirty_q <= rsp_vdirty_d;
      rsp_vtag_q   <= rsp_vtag_d;
      wb_valid_q   <= wb_valid_d;
      wb_index_q   <= wb_index_d;
      wb_tag_q     <= wb_tag_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_fence_req) begin
          state_d = S_FL_RD;
        end else if (i_req_valid && !hit) begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        if (i_refill_done) begin
          state_d = S_IDLE;
        end
      end
      S_FL_RD: begin
        if (wb_need) begin
          state_d = S_FL_WB;
        end else if (last) begin
          state_d = S_FL_DONE;
        end
      end
      S_FL_WB: begin
        if (i_wb_done) begin
          state_d = last ? S_FL_DONE : S_FL_RD;
        end
      end
      S_FL_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered datapath: counter, miss latch, response, write-back
  always_comb begin
    cnt_d        = cnt_q;
    m_idx_d      = m_idx_q;
    m_tag_d      = m_tag_q;
    m_wr_d       = m_wr_q;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = 1'b0;
    rsp_vdirty_d = 1'b0;
    rsp_vtag_d   = '0;
    wb_valid_d   = wb_valid_q;
    wb_index_d   = wb_index_q;
    wb_tag_d     = wb_tag_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          rsp_valid_d  = 1'b1;
          rsp_hit_d    = hit;
          rsp_vdirty_d = !hit && e_val && e_dirty;
          rsp_vtag_d   = e_tag;
          if (!hit) begin
            m_idx_d = req_idx;
            m_tag_d = req_tag;
            m_wr_d  = i_req_wr;
          end
        end
      end
      S_FL_RD: begin
        if (wb_need) begin
          wb_valid_d = 1'b1;
          wb_index_d = cnt_q;
          wb_tag_d   = e_tag;
        end else if (!last) begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_FL_WB: begin
        if (i_wb_done) begin
          wb_valid_d = 1'b0;
          if (!last) begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: array port, accept, fence done
  always_comb begin
    req_ready  = 1'b0;
    ary_wen    = 1'b0;
    ary_addr   = cnt_q;
    ary_din    = '0;
    fence_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = !i_fence_req;
        ary_addr  = req_idx;
        // Only a clean store hit needs the dirty bit set
        if (accept && hit && i_req_wr && !e_dirty) begin
          ary_wen = 1'b1;
          ary_din = {2'b11, req_tag};
        end
      end
      S_MISS: begin
        ary_addr = m_idx_q;
        if (i_refill_done) begin
          ary_wen = 1'b1;
          ary_din = {1'b1, m_wr_q, m_tag_q};
        end
      end
      S_FL_RD: begin
        if (!wb_need && cl_wen) begin
          ary_wen = 1'b1;
          ary_din = cl_din;
        end
      end
      S_FL_WB: begin
        if (i_wb_done && cl_wen) begin
          ary_wen = 1'b1;
          ary_din = cl_din;
        end
      end
      S_FL_DONE: fence_done = 1'b1;
      default: ;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted
  assign o_req_ready  = i_rst_n && req_ready;
  assign o_ary_wen    = i_rst_n && ary_wen;
  assign o_ary_addr   = i_rst_n ? ary_addr : 7'd0;
  assign o_ary_din    = i_rst_n ? ary_din : '0;
  assign o_fence_done = i_rst_n && fence_done;

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_hit    = rsp_hit_q;
  assign o_rsp_vdirty = rsp_vdirty_q;
  assign o_rsp_vtag   = rsp_vtag_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_index   = wb_index_q;
  assign o_wb_tag     = wb_tag_q;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb_dcache_tag_ctrl: scoreboard bench for dcache_tag_ctrl with a tag array
// model and a set-level reference of valid/dirty/tag per index.
module tb_dcache_tag_ctrl;

  localparam int TAG_W = 53;
  localparam int ENT_W = TAG_W + 2;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [63:0]      i_req_addr;
  logic             i_req_wr;
  logic             o_rsp_valid;
  logic             o_rsp_hit;
  logic             o_rsp_vdirty;
  logic [TAG_W-1:0] o_rsp_vtag;
  logic             i_refill_done;
  logic             i_fence_req;
  logic             o_fence_done;
  logic             o_wb_valid;
  logic [6:0]       o_wb_index;
  logic [TAG_W-1:0] o_wb_tag;
  logic             i_wb_done;
  logic             o_ary_wen;
  logic [6:0]       o_ary_addr;
  logic [ENT_W-1:0] o_ary_din;
  logic [ENT_W-1:0] i_ary_dout;

  dcache_tag_ctrl #(.TAG_W(TAG_W), .ENT_W(ENT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wr(i_req_wr),
    .o_rsp_valid(o_rsp_valid), .o_rsp_hit(o_rsp_hit),
    .o_rsp_vdirty(o_rsp_vdirty), .o_rsp_vtag(o_rsp_vtag),
    .i_refill_done(i_refill_done),
    .i_fence_req(i_fence_req), .o_fence_done(o_fence_done),
    .o_wb_valid(o_wb_valid), .o_wb_index(o_wb_index),
    .o_wb_tag(o_wb_tag), .i_wb_done(i_wb_done),
    .o_ary_wen(o_ary_wen), .o_ary_addr(o_ary_addr),
    .o_ary_din(o_ary_din), .i_ary_dout(i_ary_dout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Tag array model: write captured mid-cycle, committed at the clock edge
  logic [ENT_W-1:0] mem [128];
  logic             ary_clr;
  logic             pw_en;
  logic [6:0]       pw_a;
  logic [ENT_W-1:0] pw_d;

  always @(negedge i_clk) begin
    pw_en <= i_rst_n && o_ary_wen;
    pw_a  <= o_ary_addr;
    pw_d  <= o_ary_din;
  end

  always @(posedge i_clk) begin
    if (ary_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (pw_en) begin
      mem[pw_a] <= pw_d;
    end
  end

  assign i_ary_dout = mem[o_ary_addr];

  // Reference: per-set state as the cache should hold it
  bit               r_val   [128];
  bit               r_dirty [128];
  logic [TAG_W-1:0] r_tag   [128];

  typedef struct {
    int               cyc;
    bit               hit;
    bit               vdirty;
    logic [TAG_W-1:0] vtag;
  } exp_t;

  typedef struct {
    logic [6:0]       idx;
    logic [TAG_W-1:0] tag;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wbq[$];

  // Response monitor
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(o_rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_hit", 64'(o_rsp_hit), 64'(e.hit));
        if (!e.hit) begin
          chk("rsp_vdirty", 64'(o_rsp_vdirty), 64'(e.vdirty));
          chk("rsp_vtag", 64'(o_rsp_vtag), 64'(e.vtag));
        end
      end
    end
  end

  // Write-back monitor
  bit wb_prev = 1'b0;
  int wb_hi = 0;
  int fdone_cnt = 0;

  always @(negedge i_clk) begin
    wb_t w;
    if (o_wb_valid) wb_hi++;
    if (o_fence_done) fdone_cnt++;
    if (o_wb_valid && !wb_prev) begin
      if (wbq.size() == 0) begin
        chk("wb_unexpected", 64'(o_wb_index), 64'd255);
      end else begin
        w = wbq.pop_front();
        chk("wb_index", 64'(o_wb_index), 64'(w.idx));
        chk("wb_tag", 64'(o_wb_tag), 64'(w.tag));
      end
    end
    wb_prev = o_wb_valid;
  end

  // Write-back responder with random latency; can stall one index
  bit         wb_stall = 1'b0;
  logic [6:0] stall_idx = 7'd40;
  int         wb_wait = 0;

  always begin
    @(posedge i_clk);
    #1;
    if (i_wb_done) begin
      i_wb_done = 1'b0;
    end else if (i_rst_n && o_wb_valid &&
                 !(wb_stall && o_wb_index == stall_idx)) begin
      if (wb_wait == 0) begin
        i_wb_done = 1'b1;
        wb_wait = $urandom_range(0, 3);
      end else begin
        wb_wait--;
      end
    end
  end

  function automatic logic [63:0] mk_addr(input logic [TAG_W-1:0] tg,
                                          input logic [6:0] idx);
    logic [3:0] off;
    off = 4'($urandom_range(0, 15));
    return {tg, idx, off};
  endfunction

  function automatic logic [ENT_W-1:0] ref_ent(input int i);
    return {r_val[i], r_dirty[i], r_tag[i]};
  endfunction

  task automatic clean_entry(input int i);
`ifdef DCACHE_FENCE_INV_EN
    r_val[i]   = 1'b0;
    r_dirty[i] = 1'b0;
`else
    r_dirty[i] = 1'b0;
`endif
  endtask

  task automatic check_array(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== ref_ent(i)) bad++;
    end
    chk(nm, 64'(bad), 64'd0);
  endtask

  int last_wait;

  task automatic do_lookup(input logic [63:0] a, input bit wr);
    int         w;
    int         d;
    int         bad;
    bit         acc;
    bit         exp_wen;
    logic [6:0] idx;
    logic [TAG_W-1:0] tg;
    exp_t       e;
    idx = a[10:4];
    tg  = a[63:11];
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_wr    = wr;
    w = 0;
    acc = 1'b0;
    while (!acc && w < 50) begin
      @(negedge i_clk);
      if (o_req_ready) acc = 1'b1;
      else w++;
    end
    last_wait = w;
    chk("req_accept", 64'(acc), 64'd1);
    if (!acc) begin
      i_req_valid = 1'b0;
      return;
    end
    e.cyc    = cyc + 1;
    e.hit    = r_val[idx] && (r_tag[idx] == tg);
    e.vdirty = r_val[idx] && r_dirty[idx];
    e.vtag   = r_tag[idx];
    exp_q.push_back(e);
    exp_wen = e.hit && wr && !r_dirty[idx];
    chk("acc_wen", 64'(o_ary_wen), 64'(exp_wen));
    if (exp_wen) chk("acc_din", 64'(o_ary_din), 64'({2'b11, tg}));
    if (e.hit && wr) r_dirty[idx] = 1'b1;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    if (!e.hit) begin
      d = $urandom_range(0, 4);
      bad = 0;
      repeat (d) begin
        @(negedge i_clk);
        if (o_req_ready || o_ary_wen) bad++;
      end
      chk("miss_hold", 64'(bad), 64'd0);
      @(posedge i_clk);
      #1;
      i_refill_done = 1'b1;
      @(negedge i_clk);
      chk("refill_wen", 64'(o_ary_wen), 64'd1);
      chk("refill_din", 64'(o_ary_din), 64'({1'b1, wr, tg}));
      @(posedge i_clk);
      #1;
      i_refill_done = 1'b0;
      r_val[idx]   = 1'b1;
      r_dirty[idx] = wr;
      r_tag[idx]   = tg;
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      @(posedge i_clk);
      #1;
      i_refill_done = ($urandom_range(0, 3) == 0);
    end
    @(posedge i_clk);
    #1;
    i_refill_done = 1'b0;
  endtask

  task automatic expect_wbs(input int upto);
    wb_t w;
    for (int i = 0; i <= upto; i++) begin
      if (r_val[i] && r_dirty[i]) begin
        w.idx = 7'(i);
        w.tag = r_tag[i];
        wbq.push_back(w);
      end
    end
  endtask

  task automatic do_fence(input bit with_req, input logic [63:0] ra);
    int start;
    int to;
    int rbad;
    expect_wbs(127);
    wb_hi = 0;
    fdone_cnt = 0;
    @(posedge i_clk);
    #1;
    i_fence_req = 1'b1;
    if (with_req) begin
      i_req_valid = 1'b1;
      i_req_addr  = ra;
      i_req_wr    = 1'b0;
    end
    @(negedge i_clk);
    start = cyc;
    if (with_req) chk("fence_prio", 64'(o_req_ready), 64'd0);
    to = 0;
    rbad = 0;
    while (!o_fence_done && to < 3000) begin
      if (o_req_ready) rbad++;
      @(negedge i_clk);
      to++;
    end
    chk("fence_done_seen", 64'(o_fence_done), 64'd1);
    i_fence_req = 1'b0;
    chk("fence_ready_low", 64'(rbad), 64'd0);
    chk("fence_cycles", 64'(cyc - start), 64'(129 + wb_hi));
    for (int i = 0; i < 128; i++) clean_entry(i);
    if (with_req) begin
      do_lookup(ra, 1'b0);
      chk("post_fence_accept", 64'(last_wait), 64'd0);
    end else begin
      @(posedge i_clk);
      #1;
    end
    repeat (2) @(negedge i_clk);
    chk("fence_done_once", 64'(fdone_cnt), 64'd1);
    chk("wb_left", 64'(wbq.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         any;
    int         to;
    logic [6:0] ix;
    logic [TAG_W-1:0] tg;
    i_rst_n       = 1'b0;
    ary_clr       = 1'b1;
    i_req_valid   = 1'b0;
    i_req_addr    = '0;
    i_req_wr      = 1'b0;
    i_refill_done = 1'b0;
    i_fence_req   = 1'b0;
    i_wb_done     = 1'b0;
    for (int i = 0; i < 128; i++) begin
      r_val[i] = 1'b0;
      r_dirty[i] = 1'b0;
      r_tag[i] = '0;
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    any = |{o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_vdirty, o_rsp_vtag,
            o_fence_done, o_wb_valid, o_wb_index, o_wb_tag, o_ary_wen,
            o_ary_addr, o_ary_din};
    chk("reset_outs", 64'(any), 64'd0);
    ary_clr = 1'b0;
    i_rst_n = 1'b1;

    // Cold load, then hit, store hits, dirty victim
    do_lookup(64'h1230, 1'b0);
    chk("cold_refill", 64'(mem[7'h23]), 64'({2'b10, 53'h2}));
    do_lookup(64'h1230, 1'b0);
    do_lookup(64'h1230, 1'b1);
    do_lookup(64'h1238, 1'b1);
    do_lookup(64'h1A30, 1'b0);
    chk("victim_refill", 64'(mem[7'h23]), 64'({2'b10, 53'h3}));
    check_array("array_directed");

    // Dirty lines at 5 and 127, fence with a colliding request
    do_lookup(mk_addr(53'h11, 7'd5), 1'b1);
    do_lookup(mk_addr(53'h7F, 7'd127), 1'b1);
    do_lookup(mk_addr(53'h21, 7'd9), 1'b0);
    idle_gap();
    do_fence(1'b1, mk_addr(53'h3, 7'h23));
    check_array("array_fence1");

    // Random traffic over a few hot sets
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: ix = 7'h23;
        1: ix = 7'd5;
        2: ix = 7'd127;
        3: ix = 7'd40;
        4: ix = 7'd10;
        default: ix = 7'($urandom_range(0, 127));
      endcase
      tg = 53'($urandom_range(1, 4));
      do_lookup(mk_addr(tg, ix), 1'($urandom_range(0, 1)));
      idle_gap();
    end
    check_array("array_random");
    do_fence(1'b0, 64'd0);
    check_array("array_fence2");

    // Reset while stalled in write-back at index 40
    do_lookup(mk_addr(53'h7777, 7'd10), 1'b1);
    do_lookup(mk_addr(53'h7778, 7'd40), 1'b1);
    expect_wbs(40);
    wb_stall = 1'b1;
    stall_idx = 7'd40;
    fdone_cnt = 0;
    @(posedge i_clk);
    #1;
    i_fence_req = 1'b1;
    to = 0;
    while (!(o_wb_valid && o_wb_index == 7'd40) && to < 3000) begin
      @(negedge i_clk);
      to++;
    end
    chk("wb40_seen", 64'(o_wb_index), 64'd40);
    repeat (2) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    any = |{o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_vdirty, o_rsp_vtag,
            o_fence_done, o_wb_valid, o_wb_index, o_wb_tag, o_ary_wen,
            o_ary_addr, o_ary_din};
    chk("midwalk_rst_outs", 64'(any), 64'd0);
    @(posedge i_clk);
    #1;
    i_fence_req = 1'b0;
    wb_stall = 1'b0;
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) clean_entry(i);
    chk("rst_no_done", 64'(fdone_cnt), 64'd0);
    chk("rst_wb_left", 64'(wbq.size()), 64'd0);
    do_lookup(mk_addr(53'h2, 7'd77), 1'b0);
    chk("post_rst_accept", 64'(last_wait), 64'd0);
    check_array("array_after_rst");

    repeat (3) @(negedge i_clk);
    chk("rsp_left", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
